sd_cmd_response_receiver: RTL and testbench

SD_CMD_RESPONSE_RECEIVER -- requirements
Module: sd_cmd_response_receiver

---
 rtl/sd_cmd_response_receiver_pkg.sv | 24 ++
 rtl/crc7_serial.sv | 33 +++
 rtl/sd_cmd_response_receiver.sv | 167 ++++++++++++++++
 tb/tb_sd_cmd_response_receiver.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_response_receiver_pkg.sv
// Shared definitions for the SD CMD-line response receiver: frame lengths,
// CRC7 polynomial, FSM state encoding and the serial CRC7 step function.
package sd_cmd_response_receiver_pkg;

  localparam int unsigned SHORT_LEN_DEF = 48;
  localparam int unsigned LONG_LEN_DEF  = 136;

  // x^7 + x^3 + 1 with the x^7 term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    StIdle,
    StWaitStart,
    StReceive,
    StDone
  } state_e;

  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 accumulator; only built when SD_RSP_CRC_CHECK_EN is defined.
// clear restarts from zero and may coincide with enable to absorb the first bit.
`ifdef SD_RSP_CRC_CHECK_EN
module crc7_serial
  import sd_cmd_response_receiver_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d, base;

  always_comb begin
    base  = clear ? 7'h00 : crc_q;
    crc_d = enable ? crc7_next(base, din) : base;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule
`endif

// File: rtl/sd_cmd_response_receiver.sv
// SD CMD-line response receiver (48-bit R1/R3/R6/R7 and 136-bit R2 frames).
// Define SD_RSP_CRC_CHECK_EN to build the CRC7 checker; otherwise CRCERR stays 0.
module sd_cmd_response_receiver
  import sd_cmd_response_receiver_pkg::*;
#(
  parameter int unsigned TIMEOUT_CC = 64,
  parameter int unsigned SHORT_LEN  = SHORT_LEN_DEF,
  parameter int unsigned LONG_LEN   = LONG_LEN_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ENA,
  input  logic         LONGRSP,
  input  logic         SERIALRSP,
  output logic [127:0] PARALLELRSP,
  output logic         COMPLT,
  output logic         CRCERR,
  output logic         FRAMEERR,
  output logic         TIMEOUT
);

  localparam int unsigned CntMax = (LONG_LEN > TIMEOUT_CC) ? LONG_LEN : TIMEOUT_CC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [LONG_LEN-2:0] shift_q, shift_d;
  logic                long_q, long_d;
  logic [127:0]        prsp_q, prsp_d;
  logic                complt_q, complt_d;
  logic                crcerr_q, crcerr_d;
  logic                frameerr_q, frameerr_d;
  logic                timeout_q, timeout_d;

  // Whole frame as it stands once the bit now on the line is included; bit 0 is the end bit.
  logic [LONG_LEN-1:0] frame;
  logic [CntW-1:0]     last_idx;
  logic                frame_bad;
  logic                crc_bad;
  logic [127:0]        short_data, long_data;
  logic                unused_hdr;

  assign frame      = {shift_q, SERIALRSP};
  assign last_idx   = long_q ? CntW'(LONG_LEN - 1) : CntW'(SHORT_LEN - 1);
  assign frame_bad  = long_q ? (frame[LONG_LEN-2] | ~frame[0]) : (frame[SHORT_LEN-2] | ~frame[0]);
  assign short_data = 128'(frame[SHORT_LEN-3:8]);
  assign long_data  = 128'({frame[LONG_LEN-9:1], 1'b0});
  // Start, transmission and R2 reserved bits carry no payload
  assign unused_hdr = ^frame[LONG_LEN-1:LONG_LEN-8];

`ifdef SD_RSP_CRC_CHECK_EN
  logic [6:0] crc_val;
  logic       crc_clear, crc_en;

  assign crc_clear = (state_q == StWaitStart) && ENA && !SERIALRSP;
  // cnt_q is the index of the bit currently on the line while receiving
  assign crc_en = crc_clear ? !long_q :
                  (state_q == StReceive) &&
                  (long_q ? (cnt_q >= CntW'(8) && cnt_q < CntW'(LONG_LEN - 8))
                          : (cnt_q < CntW'(SHORT_LEN - 8)));
  assign crc_bad = (crc_val != frame[7:1]);

  crc7_serial u_crc7 (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (crc_clear),
    .enable (crc_en),
    .din    (SERIALRSP),
    .crc    (crc_val)
  );
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    long_d     = long_q;
    prsp_d     = prsp_q;
    complt_d   = complt_q;
    crcerr_d   = crcerr_q;
    frameerr_d = frameerr_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (ENA) begin
          state_d = StWaitStart;
          long_d  = LONGRSP;
          cnt_d   = '0;
        end
      end
      StWaitStart: begin
        if (!ENA) begin
          state_d = StIdle;
        end else if (!SERIALRSP) begin
          state_d = StReceive;
          cnt_d   = CntW'(1);
          shift_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(TIMEOUT_CC - 1)) begin
            state_d   = StDone;
            complt_d  = 1'b1;
            timeout_d = 1'b1;
          end
        end
      end
      StReceive: begin
        if (!ENA) begin
          state_d = StIdle;
        end else begin
          shift_d = frame[LONG_LEN-2:0];
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == last_idx) begin
            state_d    = StDone;
            complt_d   = 1'b1;
            frameerr_d = frame_bad;
            crcerr_d   = crc_bad;
            prsp_d     = long_q ? long_data : short_data;
          end
        end
      end
      StDone: begin
        if (!ENA) begin
          state_d    = StIdle;
          complt_d   = 1'b0;
          crcerr_d   = 1'b0;
          frameerr_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      long_q     <= 1'b0;
      prsp_q     <= '0;
      complt_q   <= 1'b0;
      crcerr_q   <= 1'b0;
      frameerr_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      long_q     <= long_d;
      prsp_q     <= prsp_d;
      complt_q   <= complt_d;
      crcerr_q   <= crcerr_d;
      frameerr_q <= frameerr_d;
      timeout_q  <= timeout_d;
    end
  end

  assign PARALLELRSP = prsp_q;
  assign COMPLT      = complt_q;
  assign CRCERR      = crcerr_q;
  assign FRAMEERR    = frameerr_q;
  assign TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_sd_cmd_response_receiver.sv
// Directed self-checking bench for sd_cmd_response_receiver; inputs driven and
// outputs sampled on the falling clock edge.
module tb_sd_cmd_response_receiver;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         ENA = 1'b0;
  logic         LONGRSP = 1'b0;
  logic         SERIALRSP = 1'b1;
  logic [127:0] PARALLELRSP;
  logic         COMPLT, CRCERR, FRAMEERR, TIMEOUT;

  int n_checks = 0;
  int n_fail = 0;

`ifdef SD_RSP_CRC_CHECK_EN
  localparam logic CrcOn = 1'b1;
`else
  localparam logic CrcOn = 1'b0;
`endif

  // Known R1 answer to CMD17: index 17, arg 0x900, CRC7 0x33
  localparam logic [47:0] R1_CMD17 = 48'h11_0000_0900_67;
  localparam logic [127:0] R1_CMD17_DATA = {90'd0, 6'h11, 32'h0000_0900};

  sd_cmd_response_receiver dut (
    .CLK         (CLK),
    .RST         (RST),
    .ENA         (ENA),
    .LONGRSP     (LONGRSP),
    .SERIALRSP   (SERIALRSP),
    .PARALLELRSP (PARALLELRSP),
    .COMPLT      (COMPLT),
    .CRCERR      (CRCERR),
    .FRAMEERR    (FRAMEERR),
    .TIMEOUT     (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] ref_crc7(input logic [135:0] bits, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = n - 1; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic arm(input logic lng);
    @(negedge CLK);
    ENA = 1'b1; LONGRSP = lng; SERIALRSP = 1'b1;
    @(negedge CLK);
    LONGRSP = 1'b0;
  endtask

  // Drive bits[n-1] first; stop after 'stop' bits. early flags COMPLT seen before the end.
  task automatic send(input logic [135:0] bits, input int n, input int stop, output logic early);
    early = 1'b0;
    for (int i = 0; i < stop; i++) begin
      if (COMPLT) early = 1'b1;
      SERIALRSP = bits[n-1-i];
      @(negedge CLK);
    end
    SERIALRSP = 1'b1;
  endtask

  task automatic drop_ena;
    ENA = 1'b0; SERIALRSP = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    #2 RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks += 5;
    if (PARALLELRSP !== 128'd0) begin n_fail++; $display("FAIL reset_prsp: got %h want 0", PARALLELRSP); end
    if (COMPLT !== 1'b0) begin n_fail++; $display("FAIL reset_complt: got %b want 0", COMPLT); end
    if (CRCERR !== 1'b0) begin n_fail++; $display("FAIL reset_crcerr: got %b want 0", CRCERR); end
    if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL reset_frameerr: got %b want 0", FRAMEERR); end
    if (TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", TIMEOUT); end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_short_zero;
    logic early;
    arm(1'b0);
    send(136'h1, 48, 48, early);
    n_checks += 7;
    if (early !== 1'b0) begin n_fail++; $display("FAIL zero_early: got %b want 0", early); end
    if (COMPLT !== 1'b1) begin n_fail++; $display("FAIL zero_complt: got %b want 1", COMPLT); end
    if (PARALLELRSP !== 128'd0) begin n_fail++; $display("FAIL zero_prsp: got %h want 0", PARALLELRSP); end
    if (CRCERR !== 1'b0) begin n_fail++; $display("FAIL zero_crcerr: got %b want 0", CRCERR); end
    if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL zero_frameerr: got %b want 0", FRAMEERR); end
    if (TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL zero_timeout: got %b want 0", TIMEOUT); end
    @(negedge CLK);
    if (COMPLT !== 1'b1) begin n_fail++; $display("FAIL zero_hold: got %b want 1", COMPLT); end
    drop_ena();
    n_checks++;
    if (COMPLT !== 1'b0) begin n_fail++; $display("FAIL zero_release: got %b want 0", COMPLT); end
  endtask

  task automatic test_short_data;
    logic early;
    arm(1'b0);
    send({88'd0, R1_CMD17}, 48, 48, early);
    n_checks += 5;
    if (early !== 1'b0) begin n_fail++; $display("FAIL r1_early: got %b want 0", early); end
    if (COMPLT !== 1'b1) begin n_fail++; $display("FAIL r1_complt: got %b want 1", COMPLT); end
    if (PARALLELRSP !== R1_CMD17_DATA) begin
      n_fail++; $display("FAIL r1_prsp: got %h want %h", PARALLELRSP, R1_CMD17_DATA);
    end
    if (CRCERR !== 1'b0) begin n_fail++; $display("FAIL r1_crcerr: got %b want 0", CRCERR); end
    if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL r1_frameerr: got %b want 0", FRAMEERR); end
    drop_ena();
  endtask

  task automatic test_crc_err;
    logic early;
    arm(1'b0);
    send(136'h3, 48, 48, early);
    n_checks += 3;
    if (COMPLT !== 1'b1) begin n_fail++; $display("FAIL crc_complt: got %b want 1", COMPLT); end
    if (CRCERR !== CrcOn) begin n_fail++; $display("FAIL crc_crcerr: got %b want %b", CRCERR, CrcOn); end
    if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL crc_frameerr: got %b want 0", FRAMEERR); end
    drop_ena();
    n_checks++;
    if (CRCERR !== 1'b0) begin n_fail++; $display("FAIL crc_clear: got %b want 0", CRCERR); end
  endtask

  task automatic test_timeout;
    logic seen;
    arm(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 63; i++) begin
      @(negedge CLK);
      if (COMPLT || TIMEOUT) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", seen); end
    @(negedge CLK);
    n_checks += 3;
    if (TIMEOUT !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", TIMEOUT); end
    if (COMPLT !== 1'b1) begin n_fail++; $display("FAIL to_complt: got %b want 1", COMPLT); end
    if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL to_frameerr: got %b want 0", FRAMEERR); end
    drop_ena();
    n_checks += 2;
    if (TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", TIMEOUT); end
    if (COMPLT !== 1'b0) begin n_fail++; $display("FAIL to_complt_clear: got %b want 0", COMPLT); end
  endtask

  task automatic test_long;
    logic [127:0] cid;
    logic [6:0]   crc;
    logic [135:0] fr;
    logic [127:0] exp;
    logic         early;
    cid = 128'h0123456789ABCDEF_FEDCBA9876543210;
    crc = ref_crc7({16'd0, cid[127:8]}, 120);
    fr  = {2'b00, 6'b111111, cid[127:8], crc, 1'b1};
    exp = {cid[127:8], crc, 1'b0};
    arm(1'b1);
    send(fr, 136, 136, early);
    n_checks += 5;
    if (early !== 1'b0) begin n_fail++; $display("FAIL r2_early: got %b want 0", early); end
    if (COMPLT !== 1'b1) begin n_fail++; $display("FAIL r2_complt: got %b want 1", COMPLT); end
    if (PARALLELRSP !== exp) begin n_fail++; $display("FAIL r2_prsp: got %h want %h", PARALLELRSP, exp); end
    if (CRCERR !== 1'b0) begin n_fail++; $display("FAIL r2_crcerr: got %b want 0", CRCERR); end
    if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL r2_frameerr: got %b want 0", FRAMEERR); end
    drop_ena();
  endtask

  task automatic test_frame_err;
    logic early;
    arm(1'b0);
    send(136'h0, 48, 48, early);
    n_checks += 2;
    if (COMPLT !== 1'b1) begin n_fail++; $display("FAIL fe_end_complt: got %b want 1", COMPLT); end
    if (FRAMEERR !== 1'b1) begin n_fail++; $display("FAIL fe_end: got %b want 1", FRAMEERR); end
    drop_ena();
    arm(1'b0);
    send({88'd0, 48'h4000_0000_0001}, 48, 48, early);
    n_checks += 2;
    if (COMPLT !== 1'b1) begin n_fail++; $display("FAIL fe_trans_complt: got %b want 1", COMPLT); end
    if (FRAMEERR !== 1'b1) begin n_fail++; $display("FAIL fe_trans: got %b want 1", FRAMEERR); end
    drop_ena();
    n_checks++;
    if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL fe_clear: got %b want 0", FRAMEERR); end
  endtask

  task automatic test_reset_mid;
    logic early;
    arm(1'b0);
    send(136'h1, 48, 48, early);
    drop_ena();
    arm(1'b0);
    send({88'd0, R1_CMD17}, 48, 20, early);
    RST = 1'b0;
    #1;
    n_checks += 2;
    if (COMPLT !== 1'b0) begin n_fail++; $display("FAIL rmid_complt: got %b want 0", COMPLT); end
    if (PARALLELRSP !== 128'd0) begin n_fail++; $display("FAIL rmid_prsp: got %h want 0", PARALLELRSP); end
    ENA = 1'b0; SERIALRSP = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    arm(1'b0);
    send({88'd0, R1_CMD17}, 48, 48, early);
    n_checks += 3;
    if (COMPLT !== 1'b1) begin n_fail++; $display("FAIL rmid_next_complt: got %b want 1", COMPLT); end
    if (PARALLELRSP !== R1_CMD17_DATA) begin
      n_fail++; $display("FAIL rmid_next_prsp: got %h want %h", PARALLELRSP, R1_CMD17_DATA);
    end
    if (CRCERR !== 1'b0) begin n_fail++; $display("FAIL rmid_next_crcerr: got %b want 0", CRCERR); end
    drop_ena();
  endtask

  task automatic test_abort;
    logic early;
    logic seen;
    arm(1'b0);
    send(136'h1, 48, 20, early);
    ENA = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (COMPLT) seen = 1'b1;
    end
    n_checks += 2;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_complt: got %b want 0", seen); end
    if (PARALLELRSP !== R1_CMD17_DATA) begin
      n_fail++; $display("FAIL abort_retain: got %h want %h", PARALLELRSP, R1_CMD17_DATA);
    end
    arm(1'b0);
    send(136'h1, 48, 48, early);
    n_checks += 3;
    if (COMPLT !== 1'b1) begin n_fail++; $display("FAIL abort_next_complt: got %b want 1", COMPLT); end
    if (PARALLELRSP !== 128'd0) begin n_fail++; $display("FAIL abort_next_prsp: got %h want 0", PARALLELRSP); end
    if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL abort_next_frameerr: got %b want 0", FRAMEERR); end
    drop_ena();
  endtask

  task automatic test_back_to_back;
    logic early;
    arm(1'b0);
    send({88'd0, R1_CMD17}, 48, 48, early);
    n_checks++;
    if (PARALLELRSP !== R1_CMD17_DATA) begin
      n_fail++; $display("FAIL b2b_first: got %h want %h", PARALLELRSP, R1_CMD17_DATA);
    end
    drop_ena();
    arm(1'b0);
    send(136'h3, 48, 48, early);
    n_checks += 3;
    if (early !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got %b want 0", early); end
    if (PARALLELRSP !== 128'd0) begin n_fail++; $display("FAIL b2b_second: got %h want 0", PARALLELRSP); end
    if (CRCERR !== CrcOn) begin n_fail++; $display("FAIL b2b_crcerr: got %b want %b", CRCERR, CrcOn); end
    drop_ena();
  endtask

  initial begin
    test_reset();
    test_short_zero();
    test_short_data();
    test_crc_err();
    test_timeout();
    test_long();
    test_frame_err();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
